address_descrambler: RTL
========================

// Module: address_descrambler
// PURPOSE
//  Inverse of the tile address scrambler: maps a physical (tile-interleaved) address back to the
//  logical address that produced it. Sits on DMA/trace/debug return paths that recover logical
//  addresses from bank-side requests. Elastic valid/ready stage with a 2-entry buffer, a tag
//  sideband, and a runtime bypass switch that takes effect only once the buffer has drained.
// PARAMETERS
//  AddrWidth          32      address width
//  ByteOffset         2       log2(bank width in bytes)
//  NumTiles           2       tiles; power of two, >=2 (if <2 the block is a pure buffer)
//  NumBanksPerTile    2       banks per tile; power of two, >=2 ($fatal otherwise)
//  SeqMemSizePerTile  4096    bytes of sequential region per tile; power of two,
//                             multiple of 2**ByteOffset*NumBanksPerTile ($fatal otherwise)
//  BaseAddr           0       region base; multiple of NumTiles*SeqMemSizePerTile ($fatal otherwise)
//  Bypass             0       reset value of the internal bypass flag
//  TagWidth           4       sideband width, carried unchanged
// PORTS
//  clk_i          in   1          clock
//  rst_ni         in   1          synchronous reset, active low
//  addr_i         in   AddrWidth  physical address
//  tag_i          in   TagWidth   sideband
//  valid_i        in   1          input valid
//  ready_o        out  1          input ready (registered, no path from ready_i)
//  addr_o         out  AddrWidth  logical address
//  tag_o          out  TagWidth   sideband, matches addr_o
//  in_seq_o       out  1          addr_o came from the sequential region and was descrambled
//  valid_o        out  1          output valid
//  ready_i        in   1          output ready
//  cfg_bypass_i   in   1          requested bypass mode (level)
//  bypass_o       out  1          bypass mode currently applied
// BEHAVIOUR
//  - Widths: L=ByteOffset+log2(NumBanksPerTile), T=log2(NumTiles), S=log2(SeqMemSizePerTile),
//    field F=addr[S+T-1:L]. Descramble when BaseAddr<=addr_i<BaseAddr+NumTiles*SeqMemSizePerTile
//    and bypass_o==0: out F = {F[T-1:0], F[S+T-L-1:T]} (tile id moves from LSBs to MSBs).
//    All other bits unchanged; outside the region or in bypass, addr_o=addr_i and in_seq_o=0.
//  - Mapping is applied at the input; the buffer stores the result, tag and in_seq.
//  - Handshake: transfer on valid&ready on either side. Once valid_o is high, addr_o/tag_o/in_seq_o
//    stay stable until the output transfer. Latency 1 cycle (accept at edge k, valid_o at k+1).
//    Full throughput, strict order.
//  - Buffer: count 0..2. ready_o = (count<2) & (state==RUN). count 2 with pop: ready_o rises
//    next cycle. Push and pop in the same cycle at count 1: count stays 1, older entry leaves.
//  - FSM RUN/DRAIN: in RUN, cfg_bypass_i!=bypass_o -> DRAIN (ready_o=0 from next cycle; the
//    input is not accepted in DRAIN). In DRAIN, when count==0: bypass_o<=cfg_bypass_i, return
//    to RUN. A cfg_bypass_i toggle back before the drain completes is still resolved at count==0
//    by sampling cfg_bypass_i then. An entry accepted in the switching cycle uses the old mode.
//  - Reset (also mid-operation): state RUN, count 0, buffered entries discarded, valid_o=0,
//    bypass_o=Bypass, addr_o/tag_o/in_seq_o=0. ready_o=1 on the first cycle after reset.
// STRUCTURE
//  - Package address_scramble_pkg: localparams L/T/S derived from the parameters, and the
//    functions scramble_addr()/descramble_addr(), so the scrambler and this block share them.
//  - Sub-module descrambler_skid_buffer (2-entry, registered ready, payload width parameterised)
//    holds {addr, tag, in_seq}. The top level holds the mapping, the FSM and bypass_o.
// TESTING (AddrWidth=32, ByteOffset=2, NumTiles=4, NumBanksPerTile=4, SeqMemSizePerTile=1024)
//  - addr_i=0x0000_0050, bypass 0 -> addr_o=0x0000_0410, in_seq_o=1, one cycle later.
//  - addr_i=0x0000_1050 (outside region) -> addr_o=0x0000_1050, in_seq_o=0.
//  - Round trip: all 1024 word addresses in 0x000..0xFFC through descramble_addr(scramble_addr(a))
//    -> identity, and through the DUT in order with random ready_i -> identity, tags preserved.
//  - ready_i=0 with 3 pushes -> ready_o=0 after 2. One pop -> ready_o=1 the next cycle, no loss or
//    reorder. Continuous valid/ready -> 1 beat/cycle.
//  - 2 entries buffered, cfg_bypass_i 0->1 -> ready_o=0, bypass_o=0 until both popped, then
//    bypass_o=1, RUN. Then 0x50 -> addr_o=0x50, in_seq_o=0.
//  - rst_ni low with 2 entries buffered -> next cycle valid_o=0, ready_o=1, bypass_o=Bypass,
//    no stale output.

Source files
------------

// File: rtl/address_scramble_pkg.sv
// Package: address_scramble_pkg
// Shared between the tile address scrambler and its inverse, the descrambler.
// Contents:
//   state_e          RUN/DRAIN states of the descrambler bypass controller
//   wide_addr_t      64-bit carrier type used by the mapping functions
//   scramble_addr()  logical -> physical (rotates the tile id from the MSBs to the LSBs)
//   descramble_addr()physical -> logical (rotates the tile id from the LSBs back to the MSBs)
// The mapping functions take the field boundaries (l, t, s) as arguments because a
// package cannot see the parameters of the module that imports it.
package address_scramble_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } state_e;

   localparam int unsigned MaxAddrWidth = 64;

   typedef logic [MaxAddrWidth-1:0] wide_addr_t;

   // Mask with the low w bits set.
   function automatic wide_addr_t field_mask(input int unsigned w);
      if (w >= MaxAddrWidth) return '1;
      return (wide_addr_t'(1) << w) - wide_addr_t'(1);
   endfunction

   // l: bank/byte offset bits, t: tile-id bits, s: log2(sequential bytes per tile).
   // The scrambled field is addr[s+t-1:l]; its top t bits (tile id) move to the bottom.
   function automatic wide_addr_t scramble_addr(input wide_addr_t addr,
                                               input int unsigned l,
                                               input int unsigned t,
                                               input int unsigned s);
      wide_addr_t  m;
      wide_addr_t  f;
      wide_addr_t  r;
      int unsigned w;
      if ((t == 0) || (s + t <= l)) return addr;
      w = s + t - l;
      if (t >= w) return addr;
      m = field_mask(w);
      f = (addr >> l) & m;
      r = ((f << t) | (f >> (w - t))) & m;
      return (addr & ~(m << l)) | (r << l);
   endfunction

   // Inverse of scramble_addr(): the tile id in the field LSBs returns to the MSBs.
   function automatic wide_addr_t descramble_addr(input wide_addr_t addr,
                                                 input int unsigned l,
                                                 input int unsigned t,
                                                 input int unsigned s);
      wide_addr_t  m;
      wide_addr_t  f;
      wide_addr_t  r;
      int unsigned w;
      if ((t == 0) || (s + t <= l)) return addr;
      w = s + t - l;
      if (t >= w) return addr;
      m = field_mask(w);
      f = (addr >> l) & m;
      r = ((f >> t) | (f << (w - t))) & m;
      return (addr & ~(m << l)) | (r << l);
   endfunction

endpackage

// File: rtl/descrambler_skid_buffer.sv
// Module: descrambler_skid_buffer
// Two-entry elastic buffer with a registered ready (no combinational path from
// ready_i to ready_o). Strict FIFO order, one beat per cycle sustained.
// Ports:
//   clk_i    in   clock
//   rst_ni   in   synchronous reset, active low; discards all entries
//   en_i     in   admission enable; when low the buffer refuses new input
//   valid_i  in   input valid
//   ready_o  out  input ready = (count < 2) & en_i
//   data_i   in   Width-bit payload
//   valid_o  out  output valid (count != 0)
//   ready_i  in   output ready
//   data_o   out  payload of the oldest entry, stable while valid_o is high
//   count_o  out  number of buffered entries, 0..2
module descrambler_skid_buffer #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [Width-1:0] data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [Width-1:0] data_o,
   output logic [1:0]       count_o
);

   logic [Width-1:0] head;   // oldest entry, drives data_o directly
   logic [Width-1:0] tail;   // second entry, only valid at count 2
   logic [1:0]       count;
   logic [1:0]       count_d;
   logic             space_q;
   logic             valid_q;
   logic             push;
   logic             pop;

   // NOTE: ready is built from flops only (space_q, and en_i which is a flop in the parent),
   // so a long ready chain downstream never reaches upstream in the same cycle.
   assign ready_o = space_q & en_i;
   assign valid_o = valid_q;
   assign data_o  = head;
   assign count_o = count;
   assign push    = valid_i & ready_o;
   assign pop     = valid_q & ready_i;

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      count_d = count;
      case ({push, pop})
         2'b10:   count_d = count + 2'd1;
         2'b01:   count_d = count - 2'd1;
         default: count_d = count;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count   <= 2'd0;
         space_q <= 1'b1;
         valid_q <= 1'b0;
         // NOTE: payload registers are reset too, because the outputs must read zero
         // straight out of reset rather than showing stale data.
         head    <= '0;
         tail    <= '0;
      end else begin
         count   <= count_d;
         space_q <= (count_d != 2'd2);
         valid_q <= (count_d != 2'd0);
         // Head loads new data when empty or when the current head leaves at count 1;
         // at count 2 a pop promotes the tail.
         if (push && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
            head <= data_i;
         end else if (pop && (count == 2'd2)) begin
            head <= tail;
         end
         if (push && (count == 2'd1) && !pop) begin
            tail <= data_i;
         end
      end
   end

endmodule

// File: rtl/address_descrambler.sv
// Module: address_descrambler
// Maps a physical (tile-interleaved) address back to its logical address and
// passes it through a 2-entry elastic stage with a tag sideband. A runtime bypass
// request is applied only after the buffer has drained, so no buffered entry ever
// sees a mode change.
// Ports:
//   clk_i         in   clock
//   rst_ni        in   synchronous reset, active low
//   addr_i        in   physical address
//   tag_i         in   sideband, carried unchanged
//   valid_i       in   input valid
//   ready_o       out  input ready (registered)
//   addr_o        out  logical address
//   tag_o         out  sideband matching addr_o
//   in_seq_o      out  addr_o came from the sequential region and was descrambled
//   valid_o       out  output valid
//   ready_i       in   output ready
//   cfg_bypass_i  in   requested bypass mode (level)
//   bypass_o      out  bypass mode currently applied
module address_descrambler
   import address_scramble_pkg::*;
#(
   parameter int unsigned          AddrWidth         = 32,
   parameter int unsigned          ByteOffset        = 2,
   parameter int unsigned          NumTiles          = 2,
   parameter int unsigned          NumBanksPerTile   = 2,
   parameter int unsigned          SeqMemSizePerTile = 4096,
   parameter logic [AddrWidth-1:0] BaseAddr          = '0,
   parameter bit                   Bypass            = 1'b0,
   parameter int unsigned          TagWidth          = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [TagWidth-1:0]  tag_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic [AddrWidth-1:0] addr_o,
   output logic [TagWidth-1:0]  tag_o,
   output logic                 in_seq_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   input  logic                 cfg_bypass_i,
   output logic                 bypass_o
);

   localparam int unsigned L            = ByteOffset + $clog2(NumBanksPerTile);
   localparam int unsigned T            = $clog2(NumTiles);
   localparam int unsigned S            = $clog2(SeqMemSizePerTile);
   localparam bit          Scramble     = (NumTiles >= 2);
   localparam wide_addr_t  RegionBase   = wide_addr_t'(BaseAddr);
   localparam wide_addr_t  RegionSize   = wide_addr_t'(NumTiles) * wide_addr_t'(SeqMemSizePerTile);
   localparam int unsigned PayloadWidth = AddrWidth + TagWidth + 1;

   // Configuration sanity: reject geometries the mapping cannot represent.
   if (AddrWidth > MaxAddrWidth) begin : g_bad_addr_width
      $fatal(1, "address_descrambler: AddrWidth must not exceed 64");
   end
   if ((NumBanksPerTile < 2) || ((NumBanksPerTile & (NumBanksPerTile - 1)) != 0)) begin : g_bad_banks
      $fatal(1, "address_descrambler: NumBanksPerTile must be a power of two >= 2");
   end
   if ((SeqMemSizePerTile == 0) || ((SeqMemSizePerTile & (SeqMemSizePerTile - 1)) != 0) ||
       ((SeqMemSizePerTile % ((2 ** ByteOffset) * NumBanksPerTile)) != 0)) begin : g_bad_seq_size
      $fatal(1, "address_descrambler: SeqMemSizePerTile must be a power of two and a multiple of the bank row");
   end
   if (Scramble && ((NumTiles & (NumTiles - 1)) != 0)) begin : g_bad_tiles
      $fatal(1, "address_descrambler: NumTiles must be a power of two");
   end
   if (Scramble && ((RegionBase % RegionSize) != 0)) begin : g_bad_base
      $fatal(1, "address_descrambler: BaseAddr must be aligned to NumTiles*SeqMemSizePerTile");
   end

   state_e                   state;
   logic                     bypass_q;
   logic                     in_seq;
   logic [AddrWidth-1:0]     mapped_addr;
   wide_addr_t               offset;
   logic [1:0]               count;
   logic [PayloadWidth-1:0]  buf_in;
   logic [PayloadWidth-1:0]  buf_out;

   assign bypass_o = bypass_q;

   // Mapping happens before the buffer, so the mode in force at acceptance is the
   // one an entry keeps. The region test uses a wrapped subtraction: addresses
   // below the base wrap to a huge offset and fail the single size comparison.
   always_comb begin
      offset      = wide_addr_t'(addr_i) - RegionBase;
      in_seq      = Scramble && (offset < RegionSize) && !bypass_q;
      mapped_addr = addr_i;
      if (in_seq) begin
         mapped_addr = AddrWidth'(descramble_addr(wide_addr_t'(addr_i), L, T, S));
      end
   end

   assign buf_in = {mapped_addr, tag_i, in_seq};

   // Bypass controller: a mode mismatch closes the input, and the new mode is
   // sampled from cfg_bypass_i only once the buffer is empty, so a request that
   // toggles back during the drain simply resolves to no change.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state    <= ST_RUN;
         bypass_q <= Bypass;
      end else begin
         case (state)
            ST_RUN: begin
               if (cfg_bypass_i != bypass_q) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (count == 2'd0) begin
                  bypass_q <= cfg_bypass_i;
                  state    <= ST_RUN;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   descrambler_skid_buffer #(
      .Width (PayloadWidth)
   ) u_buffer (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (state == ST_RUN),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (buf_in),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (buf_out),
      .count_o (count)
   );

   assign addr_o   = buf_out[PayloadWidth-1 -: AddrWidth];
   assign tag_o    = buf_out[TagWidth:1];
   assign in_seq_o = buf_out[0];

endmodule
